// File: rtl/miriscv_bus_arbiter.sv
// Two-master bus arbiter with lock support and one-cycle completion.
// Define MIRISCV_ARB_ROUND_ROBIN_EN for round-robin tie-break (default: m0 wins).
module miriscv_bus_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_grant_q;
  logic       rvalid_q;
  logic       owner_q;
  logic       g0, g1;
  logic       hold;
  logic       tie_to_m1;

`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
  assign tie_to_m1 = ~last_grant_q;
`else
  assign tie_to_m1 = 1'b0;
`endif

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    hold    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOCK0: begin
        if (m0_req_i && m0_lock_i && cnt_q < LOCK_MAX_C) begin
          hold = 1'b1;
          g0   = 1'b1;
        end else begin
          // lock holder drops to lowest priority on exit
          g1 = m1_req_i;
          g0 = m0_req_i & ~m1_req_i;
        end
      end
      LOCK1: begin
        if (m1_req_i && m1_lock_i && cnt_q < LOCK_MAX_C) begin
          hold = 1'b1;
          g1   = 1'b1;
        end else begin
          g0 = m0_req_i;
          g1 = m1_req_i & ~m0_req_i;
        end
      end
      default: begin
        g0 = m0_req_i & (~m1_req_i | ~tie_to_m1);
        g1 = m1_req_i & (~m0_req_i | tie_to_m1);
      end
    endcase
    if (hold) begin
      cnt_d = cnt_q + 8'd1;
    end else if (g0 && m0_lock_i) begin
      state_d = LOCK0;
      cnt_d   = 8'd1;
    end else if (g1 && m1_lock_i) begin
      state_d = LOCK1;
      cnt_d   = 8'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end
    if (reset) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      rvalid_q     <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= g0 | g1;
      owner_q  <= g1;
      if (g0 || g1) last_grant_q <= g1;
    end
  end

  assign m0_gnt_o    = g0;
  assign m1_gnt_o    = g1;
  assign m0_rvalid_o = rvalid_q & ~owner_q & ~reset;
  assign m1_rvalid_o = rvalid_q & owner_q & ~reset;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : 32'd0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : 32'd0;

  assign s_req_o   = g0 | g1;
  assign s_we_o    = g0 ? m0_we_i    : (g1 ? m1_we_i    : 1'b0);
  assign s_be_o    = g0 ? m0_be_i    : (g1 ? m1_be_i    : 4'd0);
  assign s_addr_o  = g0 ? m0_addr_i  : (g1 ? m1_addr_i  : 32'd0);
  assign s_wdata_o = g0 ? m0_wdata_i : (g1 ? m1_wdata_i : 32'd0);

endmodule

// File: tb/tb_miriscv_bus_arbiter.sv
// Directed self-checking bench for miriscv_bus_arbiter (LOCK_MAX=3).
// Follows MIRISCV_ARB_ROUND_ROBIN_EN for tie-break expectations.
module tb_miriscv_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_req, m1_we, m1_lock;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  miriscv_bus_arbiter #(.LOCK_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic exp_g1 [4];
  logic prev_g0, prev_g1;

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_be = 4'hF;
    m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_be = 4'hF;
    m1_addr = 32'h40; m1_wdata = 0;
    s_rdata = 0;
    next_cycle();
    m0_req = 1'b1;
    next_cycle();
    sample();
    chk("rst_gnt0", 32'(m0_gnt), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_rv0", 32'(m0_rvalid), 32'd0);
    chk("rst_rv1", 32'(m1_rvalid), 32'd0);

    // single read by m0
    next_cycle();
    reset = 1'b0; m0_addr = 32'h10;
    sample();
    chk("rd_gnt0", 32'(m0_gnt), 32'd1);
    chk("rd_gnt1", 32'(m1_gnt), 32'd0);
    chk("rd_sreq", 32'(s_req), 32'd1);
    chk("rd_saddr", s_addr, 32'h10);
    chk("rd_swe", 32'(s_we), 32'd0);
    next_cycle();
    m0_req = 1'b0; s_rdata = 32'h1234_5678;
    sample();
    chk("rd_rv0", 32'(m0_rvalid), 32'd1);
    chk("rd_rdata0", m0_rdata, 32'h1234_5678);
    chk("rd_rv1", 32'(m1_rvalid), 32'd0);
    chk("rd_rdata1", m1_rdata, 32'd0);
    chk("idle_sreq", 32'(s_req), 32'd0);
    chk("idle_saddr", s_addr, 32'd0);

    // continuous tie, no lock; last grant was m0
`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
    exp_g1 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    prev_g0 = 1'b0; prev_g1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0_req = 1'b1; m0_addr = 32'h30; m1_req = 1'b1;
      sample();
      chk($sformatf("tie_gnt1_%0d", i), 32'(m1_gnt), 32'(exp_g1[i]));
      chk($sformatf("tie_gnt0_%0d", i), 32'(m0_gnt), 32'(!exp_g1[i]));
      chk($sformatf("tie_addr_%0d", i), s_addr,
          exp_g1[i] ? 32'h40 : 32'h30);
      chk($sformatf("tie_rv0_%0d", i), 32'(m0_rvalid), 32'(prev_g0));
      chk($sformatf("tie_rv1_%0d", i), 32'(m1_rvalid), 32'(prev_g1));
      prev_g0 = !exp_g1[i]; prev_g1 = exp_g1[i];
    end
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    sample();
    chk("tie_last_rv0", 32'(m0_rvalid), 32'(prev_g0));
    chk("tie_last_rv1", 32'(m1_rvalid), 32'(prev_g1));

    // m1 locks alone, then m0 joins: 3 m1 grants then m0
    next_cycle();
    m1_req = 1'b1; m1_lock = 1'b1;
    sample();
    chk("lk_c1_gnt1", 32'(m1_gnt), 32'd1);
    next_cycle();
    m0_req = 1'b1;
    sample();
    chk("lk_c2_gnt1", 32'(m1_gnt), 32'd1);
    chk("lk_c2_gnt0", 32'(m0_gnt), 32'd0);
    chk("lk_c2_rv1", 32'(m1_rvalid), 32'd1);
    next_cycle();
    sample();
    chk("lk_c3_gnt1", 32'(m1_gnt), 32'd1);
    chk("lk_c3_gnt0", 32'(m0_gnt), 32'd0);
    next_cycle();
    sample();
    chk("lk_c4_gnt0", 32'(m0_gnt), 32'd1);
    chk("lk_c4_gnt1", 32'(m1_gnt), 32'd0);
    chk("lk_c4_rv1", 32'(m1_rvalid), 32'd1);
    next_cycle();
    m0_req = 1'b0;
    sample();
    chk("lk_c5_rv0", 32'(m0_rvalid), 32'd1);
    chk("lk_c5_gnt1", 32'(m1_gnt), 32'd1);
    next_cycle();
    m1_req = 1'b0; m1_lock = 1'b0;

    // m0 write, reset lands in its rvalid cycle
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'h3;
    m0_addr = 32'h20; m0_wdata = 32'hDEAD_BEEF;
    sample();
    chk("wr_gnt0", 32'(m0_gnt), 32'd1);
    chk("wr_swe", 32'(s_we), 32'd1);
    chk("wr_sbe", 32'(s_be), 32'h3);
    chk("wr_saddr", s_addr, 32'h20);
    chk("wr_swdata", s_wdata, 32'hDEAD_BEEF);
    next_cycle();
    reset = 1'b1; m0_req = 1'b0; m0_we = 1'b0;
    sample();
    chk("wr_rst_rv0", 32'(m0_rvalid), 32'd0);
    chk("wr_rst_sreq", 32'(s_req), 32'd0);
    next_cycle();
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h50; m1_req = 1'b1;
    sample();
    chk("post_rst_rv0", 32'(m0_rvalid), 32'd0);
    chk("post_rst_gnt0", 32'(m0_gnt), 32'd1);
    chk("post_rst_gnt1", 32'(m1_gnt), 32'd0);
    next_cycle();
    m0_req = 1'b0; m1_req = 1'b0;
    sample();
    chk("post_rst_rv0b", 32'(m0_rvalid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/miriscv_bus_arbiter.md
MIRISCV_BUS_ARBITER -- requirements
Module: miriscv_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8, giving the maximum consecutive grants one master may hold under lock (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have, for each master mX (X = 0 core LSU, X = 1 secondary master), these inputs:
- mX_req_i  1  request
- mX_we_i  1  write enable
- mX_be_i  4  byte mask
- mX_addr_i  32  address
- mX_wdata_i  32  write data
- mX_lock_i  1  hold grant for back-to-back accesses
REQ-005 SHALL have, for each master mX, these outputs:
- mX_gnt_o  1  request accepted this cycle
- mX_rvalid_o  1  access completed; read data valid
- mX_rdata_o  32  read data
REQ-006 SHALL have these slave-side ports toward the address decoder:
- s_req_o  output  1
- s_we_o  output  1
- s_be_o  output  4
- s_addr_o  output  32
- s_wdata_o  output  32
- s_rdata_i  input  32  valid one cycle after s_req_o

Function
REQ-007 SHALL grant at most one master per cycle; mX_gnt_o is combinational from the current requests and state, in the same cycle as mX_req_i.
REQ-008 SHALL drive s_req_o/we/be/addr/wdata combinationally from the granted master; with no grant, all s_* outputs SHALL be 0.
REQ-009 SHALL register the owner of each granted access and assert that master's mX_rvalid_o exactly one cycle after its grant, for reads and writes alike.
REQ-010 SHALL drive mX_rdata_o = s_rdata_i while mX_rvalid_o is high, else 0.
REQ-011 SHALL allow back-to-back grants every cycle; rvalid of access N SHALL coincide with the grant of access N+1.
REQ-012 SHALL implement FSM states IDLE, LOCK0 and LOCK1, plus register last_grant (1 bit) and a lock counter of 8 bits.
REQ-013 IDLE: with a single requester, grant it; with both requesting, apply the tie-break rule in REQ-020/021.
REQ-014 IDLE -> LOCKx SHALL occur when master x is granted with mX_lock_i=1; the lock counter is set to 1.
REQ-015 LOCKx stays in LOCKx SHALL apply when mX_req_i=1, mX_lock_i=1 and counter<LOCK_MAX: grant only x, increment the counter, and ignore the other master's request.
REQ-016 LOCKx exit SHALL apply otherwise: return to IDLE and arbitrate in the same cycle with x as lowest priority, so no grant cycle is lost.
REQ-017 SHALL update last_grant to the granted master on every grant; with no grant it is held.
REQ-018 SHALL leave requests that are not granted pending without side effects; the master must hold req and its payload stable until gnt.

Reset
REQ-019 On reset=1 at a clock edge, the block SHALL enter this state:
- state=IDLE, last_grant=1, counter=0
- both rvalid outputs 0 and any pending completion discarded
- while reset is high, both gnt outputs and s_req_o forced to 0

Configuration
REQ-020 With macro MIRISCV_ARB_ROUND_ROBIN_EN defined, an IDLE tie SHALL be granted to the master not equal to last_grant (round-robin).
REQ-021 Without MIRISCV_ARB_ROUND_ROBIN_EN, an IDLE tie SHALL always be granted to m0; lock behaviour SHALL be identical in both builds.

Verification
REQ-022 Reset release with only m0 read at addr 0x10 -> m0_gnt_o same cycle, s_addr_o=0x10; next cycle m0_rvalid_o=1 with m0_rdata_o=s_rdata_i, m1_rvalid_o=0.
REQ-023 Both masters request continuously, no lock, RR build -> grants alternate m0,m1,m0,m1, and each rvalid follows its own grant by one cycle.
REQ-024 Same stimulus as REQ-023, non-RR build -> m0 granted every cycle and m1 never granted.
REQ-025 m1 requests with lock high, LOCK_MAX=3, m0 requesting -> m1 granted 3 consecutive cycles, m0 granted on the 4th cycle.
REQ-026 m0 write be=0x3 addr 0x20 wdata 0xDEADBEEF, with reset asserted in the rvalid cycle -> write visible on s_* in the grant cycle; m0_rvalid_o=0 and s_req_o=0 during reset; state IDLE afterwards.
